// File: rtl/fp8_add_sequencer.sv
// ============================================================================
// Module   : fp8_add_sequencer
// Brief    : Operand sequencer and result register wrapping an FP8 E5M2 adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp8_add_sequencer #(
   parameter int WIDTH       = 8,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       data_in,
   input  logic                   data_valid,
   input  logic                   subtract_in,
   output logic                   data_ready,
   output logic [WIDTH-1:0]       add_a,
   output logic [WIDTH-1:0]       add_b,
   output logic                   add_subtract,
   input  logic [WIDTH-1:0]       add_result,
   output logic [WIDTH-1:0]       result_out,
   output logic                   result_valid,
   input  logic                   result_ready,
   output logic                   busy,
   output logic [COUNT_WIDTH-1:0] op_count
);

   typedef enum logic [1:0] {
      WAIT_A = 2'd0,
      WAIT_B = 2'd1,
      EXEC   = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [COUNT_WIDTH-1:0] c_count_one = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                 r_state;
   logic [WIDTH-1:0]       r_a;
   logic [WIDTH-1:0]       r_b;
   logic                   r_subtract;
   logic [WIDTH-1:0]       r_result;
   logic [COUNT_WIDTH-1:0] r_op_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= WAIT_A;
         r_a        <= '0;
         r_b        <= '0;
         r_subtract <= 1'b0;
         r_result   <= '0;
         r_op_count <= '0;
      end else begin
         case (r_state)
            WAIT_A: begin
               if (data_valid) begin
                  r_a     <= data_in;
                  r_state <= WAIT_B;
               end
            end
            WAIT_B: begin
               if (data_valid) begin
                  r_b        <= data_in;
                  r_subtract <= subtract_in;
                  r_state    <= EXEC;
               end
            end
            // Operands have been stable for a full cycle, so the adder output has settled.
            EXEC: begin
               r_result <= add_result;
               r_state  <= DONE;
            end
            DONE: begin
               if (result_ready) begin
                  r_op_count <= r_op_count + c_count_one;
                  r_state    <= WAIT_A;
               end
            end
            default: r_state <= WAIT_A;
         endcase
      end
   end

   // Status flags decode from state only, keeping them free of input-to-output paths.
   assign data_ready   = (r_state == WAIT_A) || (r_state == WAIT_B);
   assign result_valid = (r_state == DONE);
   assign busy         = (r_state == EXEC) || (r_state == DONE);

   assign add_a        = r_a;
   assign add_b        = r_b;
   assign add_subtract = r_subtract;
   assign result_out   = r_result;
   assign op_count     = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_fp8_add_sequencer.sv
// ============================================================================
// Module   : tb_fp8_add_sequencer
// Brief    : Self-checking bench for fp8_add_sequencer with a behavioural E5M2 adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp8_add_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       data_valid = 1'b0;
   logic       subtract_in = 1'b0;
   logic       data_ready;
   logic [7:0] add_a, add_b, add_result, result_out;
   logic       add_subtract, result_valid, busy;
   logic       result_ready = 1'b0;
   logic [7:0] op_count;

   int n_compared = 0;
   int n_mismatched = 0;
   int exp_count = 0;

   always #5 clk = ~clk;

   fp8_add_sequencer #(.WIDTH(8), .COUNT_WIDTH(8)) dut (
      .clk(clk), .reset(rst), .data_in(data_in), .data_valid(data_valid),
      .subtract_in(subtract_in), .data_ready(data_ready), .add_a(add_a),
      .add_b(add_b), .add_subtract(add_subtract), .add_result(add_result),
      .result_out(result_out), .result_valid(result_valid),
      .result_ready(result_ready), .busy(busy), .op_count(op_count)
   );

   function automatic real pow2(input int k);
      real v = 1.0;
      if (k >= 0) for (int i = 0; i < k; i++) v = v * 2.0;
      else        for (int i = 0; i < -k; i++) v = v / 2.0;
      return v;
   endfunction

   function automatic real fp8_value(input logic [7:0] code);
      real mag;
      int  e = int'(code[6:2]);
      int  m = int'(code[1:0]);
      if (e == 0) mag = (real'(m) / 4.0) * pow2(-14);
      else        mag = (1.0 + real'(m) / 4.0) * pow2(e - 15);
      return code[7] ? -mag : mag;
   endfunction

   // Nearest finite E5M2 code to the exact sum; results beyond range clamp to max finite.
   function automatic logic [7:0] fp8_ref(input logic [7:0] a, input logic [7:0] b, input logic sub);
      real        target = fp8_value(a) + (sub ? -fp8_value(b) : fp8_value(b));
      real        best_err = 1.0e30;
      real        err;
      logic [7:0] best = 8'h00;
      logic [7:0] code;
      for (int i = 0; i < 256; i++) begin
         code = 8'(i);
         if (code[6:2] != 5'h1F) begin
            err = fp8_value(code) - target;
            if (err < 0.0) err = -err;
            if (err < best_err) begin
               best_err = err;
               best = code;
            end
         end
      end
      return best;
   endfunction

   always_comb add_result = fp8_ref(add_a, add_b, add_subtract);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // One full operation. Inputs change and outputs are sampled at the falling edge.
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                        input int stall, input logic hold_ready);
      logic [7:0] exp_res = fp8_ref(a, b, sub);
      check("idle_ready", {31'd0, data_ready}, 32'd1);
      check("idle_busy", {31'd0, busy}, 32'd0);
      data_valid   = 1'b1;
      data_in      = a;
      subtract_in  = 1'($urandom);
      result_ready = hold_ready;
      tick();
      check("a_captured", {24'd0, add_a}, {24'd0, a});
      check("waitb_ready", {31'd0, data_ready}, 32'd1);
      data_in     = b;
      subtract_in = sub;
      tick();
      check("exec_busy", {30'd0, busy, data_ready}, 32'd2);
      check("exec_valid", {31'd0, result_valid}, 32'd0);
      check("b_captured", {23'd0, add_subtract, add_b}, {23'd0, sub, b});
      data_valid = 1'($urandom);
      data_in    = 8'hFF;
      tick();
      check("done_valid", {31'd0, result_valid}, 32'd1);
      check("result", {24'd0, result_out}, {24'd0, exp_res});
      if (!hold_ready) begin
         for (int i = 0; i < stall; i++) begin
            data_valid  = 1'($urandom);
            subtract_in = 1'($urandom);
            tick();
            check("stall_hold", {7'd0, result_valid, data_ready, add_subtract, add_a, add_b, result_out},
                  {7'd0, 1'b1, 1'b0, sub, a, b, exp_res});
         end
         result_ready = 1'b1;
      end
      tick();
      exp_count = (exp_count + 1) % 256;
      check("op_count", {24'd0, op_count}, 32'(exp_count));
      check("after_hs", {29'd0, result_valid, data_ready, busy}, 32'd2);
      check("a_held", {24'd0, add_a}, {24'd0, a});
      data_valid   = 1'b0;
      result_ready = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check(tag, {5'd0, data_ready, result_valid, busy, add_subtract, add_a, add_b, result_out},
            {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00});
      check({tag, "_count"}, {24'd0, op_count}, 32'd0);
   endtask

   initial begin
      tick();
      tick();
      rst = 1'b0;
      check_reset_state("reset");

      // Directed cases
      do_op(8'h3C, 8'h3C, 1'b0, 0, 1'b0);
      do_op(8'h40, 8'h3C, 1'b1, 0, 1'b0);
      do_op(8'h3C, 8'h3C, 1'b0, 10, 1'b0);
      check("no_spurious_capture", {31'd0, data_ready}, 32'd1);
      do_op(8'h3C, 8'h38, 1'b0, 0, 1'b1);
      do_op(8'h3E, 8'h38, 1'b0, 0, 1'b1);

      // Reset while waiting for B
      data_valid = 1'b1;
      data_in    = 8'h55;
      tick();
      data_in = 8'h66;
      rst     = 1'b1;
      tick();
      rst = 1'b0;
      data_valid = 1'b0;
      exp_count = 0;
      check_reset_state("reset_waitb");

      // Reset in DONE with the consumer ready on the same edge
      data_valid = 1'b1;
      data_in    = 8'h3C;
      tick();
      subtract_in = 1'b0;
      tick();
      data_valid = 1'b0;
      tick();
      check("pre_reset_done", {31'd0, result_valid}, 32'd1);
      result_ready = 1'b1;
      rst          = 1'b1;
      tick();
      rst          = 1'b0;
      result_ready = 1'b0;
      check_reset_state("reset_done");

      // Randomised traffic
      for (int i = 0; i < 150; i++)
         do_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 5)), 1'($urandom));

      // Counter wrap: run until the count reaches 255, then cross to 0
      while (exp_count != 255)
         do_op(8'($urandom), 8'($urandom), 1'($urandom), 0, 1'b1);
      check("count_255", {24'd0, op_count}, 32'd255);
      do_op(8'h3C, 8'h3C, 1'b0, 0, 1'b1);
      check("count_wrap", {24'd0, op_count}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

`default_nettype wire
